// File: rtl/fl_scan_reg_bank_pkg.sv
// rtl/fl_scan_reg_bank_pkg.sv - shared types and helpers for the scan register bank
//
// Contents:
//   scan_state_t : chain state (IDLE, SHIFT, FULL_ST)
//   cnt_width()  : bits needed to count 0..total inclusive
//   chan_lsb()   : LSB position of a channel inside the flat bus

package fl_scan_reg_bank_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        FULL_ST = 2'd2
    } scan_state_t;

    // The counter must represent TOTAL itself, hence total+1 values.
    function automatic int cnt_width(input int total);
        return (total < 1) ? 1 : $clog2(total + 1);
    endfunction

    // Channel c occupies bits [c*width +: width]; channel 0 is at the LSB end.
    function automatic int chan_lsb(input int chan, input int width);
        return chan * width;
    endfunction

endpackage

// File: rtl/fl_scan_chan.sv
// rtl/fl_scan_chan.sv - one channel of capture/shadow registers with masked load
//
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, loads INIT into r and q
//   shift_en  : shift r left by one, scan_in entering at bit 0
//   scan_in   : serial input (chain input or MSB of the previous channel)
//   load_en   : functional load, r and q both take d
//   commit_en : shadow update, q takes r
//   d         : parallel data for this channel
//   r         : capture register (part of the scan chain)
//   q         : shadow register (visible output)
//
// The top guarantees shift_en, load_en and commit_en are never asserted
// together; the priority order below only documents intent.

module fl_scan_chan #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             scan_in,
    input  logic             load_en,
    input  logic             commit_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_shifted;

    generate
        if (WIDTH == 1) begin : g_w1
            assign r_shifted = scan_in;
        end else begin : g_wn
            assign r_shifted = {r[WIDTH-2:0], scan_in};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r <= INIT;
            q <= INIT;
        end else if (shift_en) begin
            r <= r_shifted;
        end else if (load_en) begin
            // Functional load updates both so q behaves like a plain DFF.
            r <= d;
            q <= d;
        end else if (commit_en) begin
            q <= r;
        end
    end

endmodule

// File: rtl/fl_scan_reg_bank.sv
// rtl/fl_scan_reg_bank.sv - multi-channel register bank with scan chain and protected shadow update
//
// Ports:
//   CK   : clock, rising edge
//   CD   : synchronous active-high reset (overrides SP)
//   SP   : global clock enable; 0 freezes all state
//   SD   : 0 = functional (D0 load / UPD), 1 = scan shift
//   CE   : per-channel functional load enable
//   D0   : parallel data, channel c at [c*WIDTH +: WIDTH]
//   SI   : serial scan in (enters at bit 0)
//   UPD  : shadow update strobe
//   Q    : shadow register contents
//   SO   : serial scan out, capture MSB
//   FULL : TOTAL shifts accumulated since last update/reset
//   ERR  : one-cycle pulse when UPD arrives with an incomplete chain

module fl_scan_reg_bank
    import fl_scan_reg_bank_pkg::*;
#(
    parameter int                        WIDTH    = 8,
    parameter int                        CHANNELS = 4,
    parameter logic [WIDTH*CHANNELS-1:0] INIT     = '0
) (
    input  logic                      CK,
    input  logic                      CD,
    input  logic                      SP,
    input  logic                      SD,
    input  logic [CHANNELS-1:0]       CE,
    input  logic [WIDTH*CHANNELS-1:0] D0,
    input  logic                      SI,
    input  logic                      UPD,
    output logic [WIDTH*CHANNELS-1:0] Q,
    output logic                      SO,
    output logic                      FULL,
    output logic                      ERR
);

    localparam int             TOTAL   = WIDTH * CHANNELS;
    localparam int             CW      = cnt_width(TOTAL);
    localparam logic [CW-1:0]  TOTAL_C = CW'(TOTAL);

    scan_state_t   state;
    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;
    logic          err_q;
    logic [TOTAL-1:0] r;
    // chain[0] is SI, chain[i] is r[i-1]; chain[TOTAL] is the scan output.
    logic [TOTAL:0]   chain;

    logic do_shift;
    logic upd_cmd;
    logic do_commit;
    logic do_load;

    assign chain = {r, SI};

    // Shift wins over UPD; UPD wins over functional load.
    assign do_shift  = SP & SD;
    assign upd_cmd   = SP & ~SD & UPD;
    assign do_commit = upd_cmd & (state != SHIFT);
    // Functional traffic is locked out while a scan is in progress.
    assign do_load   = SP & ~SD & ~UPD & (state == IDLE);

    assign count_inc = (count == TOTAL_C) ? TOTAL_C : count + CW'(1);

    always_ff @(posedge CK) begin
        if (CD) begin
            state <= IDLE;
            count <= '0;
            err_q <= 1'b0;
        end else if (!SP) begin
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (SD) begin
                count <= count_inc;
                state <= (count_inc == TOTAL_C) ? FULL_ST : SHIFT;
            end else if (UPD) begin
                if (state == SHIFT) begin
                    // Incomplete chain: refuse the update, keep everything.
                    err_q <= 1'b1;
                end else begin
                    state <= IDLE;
                    count <= '0;
                end
            end
        end
    end

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
            localparam int LSB = chan_lsb(c, WIDTH);

            fl_scan_chan #(
                .WIDTH (WIDTH),
                .INIT  (INIT[LSB +: WIDTH])
            ) u_chan (
                .clk       (CK),
                .rst       (CD),
                .shift_en  (do_shift),
                .scan_in   (chain[LSB]),
                .load_en   (do_load & CE[c]),
                .commit_en (do_commit),
                .d         (D0[LSB +: WIDTH]),
                .r         (r[LSB +: WIDTH]),
                .q         (Q[LSB +: WIDTH])
            );
        end
    endgenerate

    assign SO   = chain[TOTAL];
    assign FULL = (state == FULL_ST);
    assign ERR  = err_q;

endmodule

// File: tb/tb_fl_scan_reg_bank.sv
// tb/tb_fl_scan_reg_bank.sv - directed table-driven bench for fl_scan_reg_bank

module tb_fl_scan_reg_bank;

    logic       CK = 1'b0;
    logic       CD, SP, SD, SI, UPD;
    logic [1:0] CE;
    logic [7:0] D0;
    logic [7:0] Q;
    logic       SO, FULL, ERR;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       cd, sp, sd, upd;
        logic [1:0] ce;
        logic [7:0] d0;
        logic       si;
        logic [7:0] q;
        logic       so, full, err;
    } vec_t;

    vec_t tv[$];

    fl_scan_reg_bank #(
        .WIDTH    (4),
        .CHANNELS (2),
        .INIT     (8'hA5)
    ) dut (
        .CK   (CK),
        .CD   (CD),
        .SP   (SP),
        .SD   (SD),
        .CE   (CE),
        .D0   (D0),
        .SI   (SI),
        .UPD  (UPD),
        .Q    (Q),
        .SO   (SO),
        .FULL (FULL),
        .ERR  (ERR)
    );

    always #5 CK = ~CK;

    task automatic add(input logic cd, sp, sd, upd, input logic [1:0] ce,
                       input logic [7:0] d0, input logic si,
                       input logic [7:0] q, input logic so, full, err);
        vec_t v;
        v.cd = cd; v.sp = sp; v.sd = sd; v.upd = upd; v.ce = ce; v.d0 = d0;
        v.si = si; v.q = q; v.so = so; v.full = full; v.err = err;
        tv.push_back(v);
    endtask

    task automatic step(input logic cd, sp, sd, upd, input logic [1:0] ce,
                        input logic [7:0] d0, input logic si);
        CD = cd; SP = sp; SD = sd; UPD = upd; CE = ce; D0 = d0; SI = si;
        @(posedge CK);
        #1;
    endtask

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] q,
                             input logic so, full, err);
        cmp({tag, " Q"},    Q,           q);
        cmp({tag, " SO"},   {7'd0, SO},   {7'd0, so});
        cmp({tag, " FULL"}, {7'd0, FULL}, {7'd0, full});
        cmp({tag, " ERR"},  {7'd0, ERR},  {7'd0, err});
    endtask

    initial begin
        CD = 1'b1; SP = 1'b0; SD = 1'b0; UPD = 1'b0; CE = '0; D0 = '0; SI = 1'b0;

        // Reset (overrides SP=0), then SP=0 freezes everything.
        add(1,0,0,0,2'b00,8'h00,0, 8'hA5,1,0,0);
        add(0,0,1,1,2'b11,8'hFF,0, 8'hA5,1,0,0);
        add(0,0,0,0,2'b11,8'h00,1, 8'hA5,1,0,0);
        add(0,0,0,1,2'b01,8'h3C,1, 8'hA5,1,0,0);
        add(0,0,1,0,2'b10,8'hFF,1, 8'hA5,1,0,0);
        add(0,0,0,0,2'b00,8'h00,0, 8'hA5,1,0,0);
        // Masked functional loads.
        add(0,1,0,0,2'b01,8'h3C,0, 8'hAC,1,0,0);
        add(0,1,0,0,2'b11,8'h00,0, 8'h00,0,0,0);
        // Full scan 1,0,0,1,1,1,0,1.
        add(0,1,1,0,2'b00,8'h00,1, 8'h00,0,0,0);
        add(0,1,1,0,2'b00,8'h00,0, 8'h00,0,0,0);
        add(0,1,1,0,2'b00,8'h00,0, 8'h00,0,0,0);
        add(0,1,1,0,2'b00,8'h00,1, 8'h00,0,0,0);
        add(0,1,1,0,2'b00,8'h00,1, 8'h00,0,0,0);
        add(0,1,1,0,2'b00,8'h00,1, 8'h00,0,0,0);
        add(0,1,1,0,2'b00,8'h00,0, 8'h00,0,0,0);
        add(0,1,1,0,2'b11,8'hFF,1, 8'h00,1,1,0);
        // Update in FULL_ST (CE ignored), then harmless re-commit in IDLE.
        add(0,1,0,1,2'b11,8'hFF,0, 8'h9D,1,0,0);
        add(0,1,0,1,2'b00,8'h00,0, 8'h9D,1,0,0);
        // Premature update after 3 shifts.
        add(0,1,1,0,2'b00,8'h00,0, 8'h9D,0,0,0);
        add(0,1,1,0,2'b00,8'h00,1, 8'h9D,0,0,0);
        add(0,1,1,0,2'b00,8'h00,0, 8'h9D,1,0,0);
        add(0,1,0,1,2'b00,8'h00,0, 8'h9D,1,0,1);
        add(0,1,0,0,2'b11,8'h00,0, 8'h9D,1,0,0);
        add(0,1,1,0,2'b00,8'h00,1, 8'h9D,1,0,0);
        add(0,1,1,0,2'b00,8'h00,0, 8'h9D,1,0,0);
        add(0,1,1,0,2'b00,8'h00,1, 8'h9D,0,0,0);
        add(0,1,1,0,2'b00,8'h00,0, 8'h9D,1,0,0);
        add(0,1,1,0,2'b00,8'h00,1, 8'h9D,0,1,0);
        add(0,1,0,1,2'b00,8'h00,0, 8'h55,0,0,0);
        // Clear R, then 10 shifts of ones: saturation, no wrap.
        add(0,1,0,0,2'b11,8'h00,0, 8'h00,0,0,0);
        for (int k = 1; k <= 10; k++)
            add(0,1,1,0,2'b00,8'h00,1, 8'h00,(k >= 8),(k >= 8),0);
        add(0,1,0,1,2'b00,8'h00,0, 8'hFF,1,0,0);
        // ERR pulse, and SP=0 with UPD still high clears it.
        add(0,1,1,0,2'b00,8'h00,0, 8'hFF,1,0,0);
        add(0,1,0,1,2'b00,8'h00,0, 8'hFF,1,0,1);
        add(0,0,0,1,2'b00,8'h00,0, 8'hFF,1,0,0);

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].cd, tv[i].sp, tv[i].sd, tv[i].upd, tv[i].ce, tv[i].d0, tv[i].si);
            check_all($sformatf("row%0d", i), tv[i].q, tv[i].so, tv[i].full, tv[i].err);
        end

        // Reset mid-scan: 4 shifts, reset with SP/SD high, then shift+UPD.
        for (int k = 0; k < 4; k++)
            step(0,1,1,0,2'b00,8'h00,1);
        check_all("mid_scan", 8'hFF, 1'b1, 1'b0, 1'b0);
        step(1,1,1,0,2'b11,8'h00,0);
        check_all("mid_reset", 8'hA5, 1'b1, 1'b0, 1'b0);
        step(0,1,1,1,2'b00,8'h00,0);
        check_all("shift_upd", 8'hA5, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++)
            step(0,1,1,0,2'b00,8'h00,0);
        check_all("post_rst_7", 8'hA5, 1'b1, 1'b0, 1'b0);
        step(0,1,1,0,2'b00,8'h00,0);
        check_all("post_rst_8", 8'hA5, 1'b0, 1'b1, 1'b0);
        step(0,1,0,1,2'b00,8'h00,0);
        check_all("final_upd", 8'h00, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fl_scan_reg_bank.md
Name: fl_scan_reg_bank

Overview:
- Parametrised multi-channel register bank. Each channel is WIDTH bits.
- Two input modes per clock:
  - Functional mode: parallel load from D0, with a per-channel load mask.
  - Scan mode: serial shift of a capture chain. A protected shadow update then transfers the chain to the outputs.
- Successor to the single-bit mux-input, clock-enabled flip-flop cells. Used wherever the design needs a wide, scan-loadable configuration or pipeline register with glitch-free output update.

Parameters:
- WIDTH, 8, bits per channel (>=1)
- CHANNELS, 4, number of channels (>=1); TOTAL = WIDTH*CHANNELS
- INIT, 0, reset value of capture and shadow registers (TOTAL bits)

Ports:
- CK  input  1  clock; all state updates on rising edge
- CD  input  1  reset, synchronous, active-high
- SP  input  1  global clock enable; SP=0 freezes all state and ignores every other control
- SD  input  1  mode select: 0 = functional (D0 / UPD), 1 = scan shift
- CE  input  CHANNELS  per-channel functional load enable
- D0  input  TOTAL  parallel data; channel c occupies bits [c*WIDTH +: WIDTH]
- SI  input  1  serial scan in
- UPD  input  1  shadow update strobe (copy capture chain to Q)
- Q  output  TOTAL  shadow register contents
- SO  output  1  serial scan out = capture MSB (combinational from register)
- FULL  output  1  high when TOTAL shifts have accumulated since last update/reset
- ERR  output  1  one-cycle pulse: UPD rejected because the chain was incomplete

Behaviour:
- Reset (CD=1 at edge, highest priority, overrides SP):
  - capture R = INIT, shadow Q = INIT, count = 0, state = IDLE
  - FULL = 0, ERR = 0, SO = INIT[TOTAL-1]
- State machine:
  - States: IDLE, SHIFT, FULL_ST.
  - FULL = (state == FULL_ST).
  - Counter width is clog2(TOTAL+1).
- SP=0:
  - No state change.
  - ERR drops to 0; ERR is always a single-cycle pulse.
- SP=1, SD=1 (shift), in any state:
  - R <= {R[TOTAL-2:0], SI}; for TOTAL=1, R <= SI.
  - count <= min(count+1, TOTAL).
  - Next state = FULL_ST if the new count == TOTAL, else SHIFT.
  - Shifting in FULL_ST continues; count saturates at TOTAL.
  - Q holds throughout.
- SP=1, SD=0, UPD=1:
  - In FULL_ST: Q <= R, count <= 0, state <= IDLE.
  - In SHIFT: ignored (R, Q, count, state held); ERR = 1 next cycle.
  - In IDLE: Q <= R (re-commit, harmless), no ERR.
  - UPD has priority over functional load; CE is ignored that cycle.
- SP=1, SD=0, UPD=0:
  - In IDLE only: for each channel c with CE[c]=1, R[c] <= D0[c] and Q[c] <= D0[c]. Unmasked channels hold.
  - Q latency is 1 cycle, same as a plain D flip-flop.
  - In SHIFT or FULL_ST: hold. A partial scan is never corrupted by functional traffic.
- SD=1 together with UPD=1: shift wins; UPD is ignored without ERR.
- Reset during SHIFT or FULL_ST: the partial chain is discarded, and Q returns to INIT, not to the pre-scan value.
- Channel 0 sits at the LSB end. Scan data enters at bit 0 and exits at bit TOTAL-1, so the first bit shifted in ends up in R[TOTAL-1] after TOTAL shifts.

Decomposition:
- Shared package:
  - state enum {IDLE, SHIFT, FULL_ST}
  - clog2-based counter-width function
  - channel slice helper constant: WIDTH offset per channel
- One natural sub-module: fl_scan_chan, a single-channel capture/shadow slice with mask load.
  - Instantiated CHANNELS times with generate.
  - The FSM and counter stay in the top.

Test Plan:
- Reset values (WIDTH=4, CHANNELS=2, INIT=8'hA5): assert CD one cycle -> Q=8'hA5, SO=1, FULL=0, ERR=0; hold SP=0 for 5 cycles afterwards -> unchanged.
- Masked functional load: IDLE, SP=1, SD=0, CE=2'b01, D0=8'h3C -> next cycle Q=8'hAC (channel 1 holds A, channel 0 loads C); then CE=2'b11, D0=8'h00 -> Q=8'h00.
- Full scan and update: SD=1 for 8 cycles shifting SI=1,0,0,1,1,1,0,1 -> FULL=1 after 8th edge, Q unchanged; SD=0, UPD=1 -> Q=8'h9D, FULL=0, state IDLE.
- Premature update: 3 shifts, then SD=0, UPD=1 -> ERR high for exactly one cycle, Q unchanged; a functional load with CE=2'b11 is then ignored; 5 more shifts -> FULL=1; UPD accepted.
- Saturation and SO: 10 shifts of SI=1 from R=8'h00 -> SO goes 1 on the 8th edge, count saturates, FULL stays 1, no wrap.
- Reset mid-scan: after 4 shifts, CD=1 -> R=Q=INIT, FULL=0; SD=1 together with UPD=1 -> shift occurs, no ERR, Q held.
